// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared pipeline constants: NOP encoding, opcodes of interest and the
// forwarding-select encoding used by the hazard controller.
package pipe_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    localparam logic [4:0]  OP_HALT   = 5'b00000;
    localparam logic [4:0]  OP_RET    = 5'b01110;

    // Select 0 reads the register file; select k takes entry k-1.
    localparam int          FWD_SEL_RF = 0;

    typedef enum logic [1:0] {
        HZ_NONE  = 2'd0,
        HZ_FWD   = 2'd1,
        HZ_STALL = 2'd2
    } hz_kind_t;

    function automatic int fwd_sel_of(input int entry_idx);
        return entry_idx + 1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_match.sv
// Compares one ID source register against the in-flight scoreboard chain and
// reports the youngest (lowest index) matching entry.
module hazard_match
    import pipe_pkg::*;
#(
    parameter int NREGS    = 8,
    parameter int DEPTH    = 3,
    parameter int RF_WT    = 1,
    parameter int ZERO_REG = 0,
    parameter int RW       = $clog2(NREGS),
    parameter int FW       = $clog2(DEPTH+1)
) (
    input  logic                  i_id_valid,
    input  logic [RW-1:0]         i_src,
    input  logic                  i_used,
    input  logic [DEPTH-1:0]      i_v,
    input  logic [DEPTH*RW-1:0]   i_rd,
    input  logic [DEPTH-1:0]      i_ld,
    output logic                  o_hit,
    output logic [FW-1:0]         o_idx,
    output logic                  o_ld
);

    logic             w_src_ok;
    logic [DEPTH-1:0] w_match;

    assign w_src_ok = i_id_valid && i_used && !((ZERO_REG != 0) && (i_src == '0));

    // With write-through the WB entry's value is already visible in the RF read.
    for (genvar k = 0; k < DEPTH; k++) begin : g_ent
        localparam bit IGNORE = (RF_WT != 0) && (k == DEPTH-1);
        assign w_match[k] = !IGNORE && i_v[k] && (i_rd[k*RW +: RW] == i_src) && w_src_ok;
    end

    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        o_ld  = 1'b0;
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (w_match[k]) begin
                o_hit = 1'b1;
                o_idx = FW'(k);
                o_ld  = i_ld[k];
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller: scoreboard chain of in-flight destinations,
// forwarding selects, load-use stall, branch flush, memory hold, perf counters.
module hazard_ctrl_unit
    import pipe_pkg::*;
#(
    parameter int NREGS    = 8,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int FWD_EN   = 1,
    parameter int RF_WT    = 1,
    parameter int ZERO_REG = 0,
    parameter int CNTW     = 16,
    parameter int RW       = $clog2(NREGS),
    parameter int FW       = $clog2(DEPTH+1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RW-1:0]   id_rs1,
    input  logic            id_rs1_used,
    input  logic [RW-1:0]   id_rs2,
    input  logic            id_rs2_used,
    input  logic            id_wr,
    input  logic [RW-1:0]   id_rd,
    input  logic            id_is_load,
    input  logic            ex_bt,
    input  logic            dmem_ready,
    output logic            stall,
    output logic            flush,
    output logic            hold,
    output logic [FW-1:0]   fwd_a,
    output logic [FW-1:0]   fwd_b,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    logic [DEPTH-1:0]    r_v;
    logic [DEPTH*RW-1:0] r_rd;
    logic [DEPTH-1:0]    r_ld;
    logic [CNTW-1:0]     r_stall_cnt;
    logic [CNTW-1:0]     r_flush_cnt;

    logic                w_hit_a, w_hit_b;
    logic [FW-1:0]       w_idx_a, w_idx_b;
    logic                w_ld_a, w_ld_b;
    hz_kind_t            w_kind_a, w_kind_b;
    logic                w_need_stall;
    logic                w_new_v;

    hazard_match #(
        .NREGS(NREGS), .DEPTH(DEPTH), .RF_WT(RF_WT), .ZERO_REG(ZERO_REG)
    ) u_match_a (
        .i_id_valid (id_valid),
        .i_src      (id_rs1),
        .i_used     (id_rs1_used),
        .i_v        (r_v),
        .i_rd       (r_rd),
        .i_ld       (r_ld),
        .o_hit      (w_hit_a),
        .o_idx      (w_idx_a),
        .o_ld       (w_ld_a)
    );

    hazard_match #(
        .NREGS(NREGS), .DEPTH(DEPTH), .RF_WT(RF_WT), .ZERO_REG(ZERO_REG)
    ) u_match_b (
        .i_id_valid (id_valid),
        .i_src      (id_rs2),
        .i_used     (id_rs2_used),
        .i_v        (r_v),
        .i_rd       (r_rd),
        .i_ld       (r_ld),
        .o_hit      (w_hit_b),
        .o_idx      (w_idx_b),
        .o_ld       (w_ld_b)
    );

    // A load is forwardable only once it has reached entry LOAD_LAT.
    function automatic hz_kind_t classify(input logic hit, input logic ld,
                                          input logic [FW-1:0] idx);
        if (!hit)
            return HZ_NONE;
        if (FWD_EN == 0)
            return HZ_STALL;
        if (ld && (idx < FW'(LOAD_LAT)))
            return HZ_STALL;
        return HZ_FWD;
    endfunction

    assign w_kind_a     = classify(w_hit_a, w_ld_a, w_idx_a);
    assign w_kind_b     = classify(w_hit_b, w_ld_b, w_idx_b);
    assign w_need_stall = (w_kind_a == HZ_STALL) || (w_kind_b == HZ_STALL);

    assign hold  = !dmem_ready;
    assign flush = !hold && ex_bt;
    assign stall = !hold && !ex_bt && w_need_stall;

    assign fwd_a = (w_kind_a == HZ_FWD) ? FW'(fwd_sel_of(int'(w_idx_a))) : FW'(FWD_SEL_RF);
    assign fwd_b = (w_kind_b == HZ_FWD) ? FW'(fwd_sel_of(int'(w_idx_b))) : FW'(FWD_SEL_RF);

    assign w_new_v = id_valid && id_wr && !stall && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v  <= '0;
            r_rd <= '0;
            r_ld <= '0;
        end else if (!hold) begin
            r_v  <= {r_v[DEPTH-2:0], w_new_v};
            r_rd <= {r_rd[(DEPTH-1)*RW-1:0], id_rd};
            r_ld <= {r_ld[DEPTH-2:0], id_is_load};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!hold) begin
            if (stall && (r_stall_cnt != {CNTW{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (flush && (r_flush_cnt != {CNTW{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
